// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, occupancy width helper and control typedef for the elastic pipe chain
package pipe_pkg;

    localparam int MAX_PIPE_DEPTH = 16;

    typedef struct packed {
        logic valid;
        logic flush;
        logic ready;
    } pipe_stage_ctrl_t;

    // Room for 0..DEPTH stage entries plus one skid entry.
    function automatic int clog2_occ(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// rtl/elastic_pipe_stage.sv - one elastic register stage holding a valid bit and a payload word
module elastic_pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uv,
    input  logic [WIDTH-1:0] up_data,
    input  logic             rdy,
    input  logic             flush,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_d
);
    logic [WIDTH-1:0] data_d;

    // A flushed stage always sees rdy=1, so the hold branch never carries killed content.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (rdy) begin
            valid_d = uv;
            if (uv) begin
                data_d = up_data;
            end else if (flush && FLUSH_ZERO) begin
                data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/elastic_pipe_chain.sv
// rtl/elastic_pipe_chain.sv - DEPTH-stage elastic valid/ready pipeline with per-stage flush and occupancy
// Optional ELASTIC_PIPE_SKID_EN adds a one-entry skid register that makes in_ready registered.
module elastic_pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int FLUSH_ZERO = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    input  logic [DEPTH-1:0]            flush,
    output logic [DEPTH-1:0]            stage_valid,
    output logic [clog2_occ(DEPTH)-1:0] occupancy
);
    localparam int OCC_W = clog2_occ(DEPTH);

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] valid_nxt;
    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] uv;
    logic [WIDTH-1:0] up_data    [DEPTH];
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             skid_cnt;
    logic [OCC_W-1:0] occupancy_q;
    logic [OCC_W-1:0] occupancy_d;

    assign ev = valid_vec & ~flush;

    // Empty or flushed stages pass ready through, so bubbles collapse.
    always_comb begin : ready_chain
        logic r;
        r            = ~ev[DEPTH-1] | out_ready;
        rdy          = '0;
        rdy[DEPTH-1] = r;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            r      = ~ev[i] | r;
            rdy[i] = r;
        end
    end

    always_comb begin
        uv         = '0;
        uv[0]      = src_valid;
        up_data[0] = src_data;
        for (int i = 1; i < DEPTH; i++) begin
            uv[i]      = ev[i-1];
            up_data[i] = stage_data[i-1];
        end
    end

`ifdef ELASTIC_PIPE_SKID_EN
    logic             skid_full_q;
    logic             skid_full_d;
    logic [WIDTH-1:0] skid_data_q;
    logic [WIDTH-1:0] skid_data_d;
    logic             in_fire;

    assign in_ready  = ~skid_full_q & ~reset;
    assign in_fire   = in_valid & in_ready;
    assign src_valid = skid_full_q | in_valid;
    assign src_data  = skid_full_q ? skid_data_q : in_data;
    assign skid_cnt  = skid_full_d;

    // The skid word is older than anything on in_data, so it drains first.
    always_comb begin
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        if (skid_full_q) begin
            if (rdy[0]) begin
                skid_full_d = 1'b0;
            end
        end else if (in_fire && !rdy[0]) begin
            skid_full_d = 1'b1;
            skid_data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    assign in_ready  = rdy[0] & ~reset;
    assign src_valid = in_valid;
    assign src_data  = in_data;
    assign skid_cnt  = 1'b0;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        elastic_pipe_stage #(
            .WIDTH      (WIDTH),
            .FLUSH_ZERO (FLUSH_ZERO != 0)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .uv      (uv[g]),
            .up_data (up_data[g]),
            .rdy     (rdy[g]),
            .flush   (flush[g]),
            .valid_q (valid_vec[g]),
            .data_q  (stage_data[g]),
            .valid_d (valid_nxt[g])
        );
    end

    // Counting next-state valids keeps the registered count aligned with stage_valid.
    always_comb begin
        occupancy_d = OCC_W'(skid_cnt);
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + OCC_W'(valid_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign out_valid   = ev[DEPTH-1];
    assign out_data    = stage_data[DEPTH-1];
    assign stage_valid = valid_vec;
    assign occupancy   = occupancy_q;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// tb/tb_elastic_pipe_chain.sv - directed and randomized self-checking bench for elastic_pipe_chain
module tb_elastic_pipe_chain;
    import pipe_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int OCC_W = clog2_occ(DEPTH);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [DEPTH-1:0] flush;
    logic [DEPTH-1:0] stage_valid;
    logic [OCC_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;
    int peak   = 0;

    // Reference model: a row of DEPTH slots where words slide forward into free space.
    bit               m_v [DEPTH];
    logic [WIDTH-1:0] m_d [DEPTH];
    bit               m_sf;
    logic [WIDTH-1:0] m_sd;

    logic [WIDTH-1:0] dut_outs [$];
    logic [WIDTH-1:0] exp_q    [$];

    elastic_pipe_chain #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .FLUSH_ZERO (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_count"}, 64'(dut_outs.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < dut_outs.size()) begin
                check($sformatf("%s_word%0d", tag, i), 64'(dut_outs[i]), 64'(exp_q[i]));
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = $urandom;
        out_ready = 1'($urandom_range(0, 1));
        flush     = '0;
        #1;
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_sf = 1'b0;
        m_sd = '0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_stage_valid", 64'(stage_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic cycle(input bit iv, input logic [WIDTH-1:0] id, input bit ordy,
                         input logic [DEPTH-1:0] fl);
        bit               live [DEPTH];
        bit               nv   [DEPTH];
        logic [WIDTH-1:0] nd   [DEPTH];
        bit               nsf;
        logic [WIDTH-1:0] nsd;
        bit               exp_ir;
        bit               exp_ov;
        logic [WIDTH-1:0] exp_od;
        logic [DEPTH-1:0] exp_sv;
        int               exp_occ;

        for (int i = 0; i < DEPTH; i++) begin
            live[i] = m_v[i] && !fl[i];
            nv[i]   = 1'b0;
            nd[i]   = fl[i] ? '0 : m_d[i];
        end
        exp_ov = live[DEPTH-1];
        exp_od = m_d[DEPTH-1];
        if (live[DEPTH-1] && !ordy) nv[DEPTH-1] = 1'b1;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (live[i]) begin
                if (!nv[i+1]) begin
                    nv[i+1] = 1'b1;
                    nd[i+1] = m_d[i];
                end else begin
                    nv[i] = 1'b1;
                end
            end
        end
        nsf = m_sf;
        nsd = m_sd;
`ifdef ELASTIC_PIPE_SKID_EN
        exp_ir = !m_sf;
        if (!nv[0]) begin
            if (m_sf) begin
                nv[0] = 1'b1;
                nd[0] = m_sd;
                nsf   = 1'b0;
            end else if (iv) begin
                nv[0] = 1'b1;
                nd[0] = id;
            end
        end else if (!m_sf && iv) begin
            nsf = 1'b1;
            nsd = id;
        end
`else
        exp_ir = !nv[0];
        if (iv && !nv[0]) begin
            nv[0] = 1'b1;
            nd[0] = id;
        end
`endif

        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check("in_ready", 64'(in_ready), 64'(exp_ir));
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) check("out_data", 64'(out_data), 64'(exp_od));
        if (out_valid && out_ready) dut_outs.push_back(out_data);

        @(posedge clk);
        #1;
        exp_occ = int'(nsf);
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i]    = nv[i];
            m_d[i]    = nd[i];
            exp_sv[i] = nv[i];
            exp_occ  += int'(nv[i]);
        end
        m_sf = nsf;
        m_sd = nsd;
        check("stage_valid", 64'(stage_valid), 64'(exp_sv));
        check("occupancy", 64'(occupancy), 64'(exp_occ));
        if (int'(occupancy) > peak) peak = int'(occupancy);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = '0;

        // Streaming with out_ready held high.
        do_reset();
        dut_outs.delete();
        peak = 0;
        cycle(1'b1, 32'h11, 1'b1, '0);
        cycle(1'b1, 32'h22, 1'b1, '0);
        cycle(1'b1, 32'h33, 1'b1, '0);
        check("t1_no_early_out", 64'(out_valid), 64'd0);
        cycle(1'b0, '0, 1'b1, '0);
        check("t1_latency_valid", 64'(out_valid), 64'd1);
        check("t1_latency_data", 64'(out_data), 64'h11);
        repeat (5) cycle(1'b0, '0, 1'b1, '0);
        exp_q.delete();
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h33);
        check_outs("t1_stream");
        check("t1_peak_occ", 64'(peak), 64'd3);

        // Bubbles collapse under backpressure.
        do_reset();
        dut_outs.delete();
        cycle(1'b1, 32'hA0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0);
        cycle(1'b1, 32'hB0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0);
        check("t2_collapse", 64'(stage_valid), 64'hC);
        check("t2_in_ready_room", 64'(in_ready), 64'd1);
        cycle(1'b1, 32'hC0, 1'b0, '0);
        cycle(1'b1, 32'hD0, 1'b0, '0);
        check("t2_full", 64'(stage_valid), 64'hF);
`ifndef ELASTIC_PIPE_SKID_EN
        check("t2_in_ready_full", 64'(in_ready), 64'd0);
`endif
        repeat (6) cycle(1'b0, '0, 1'b1, '0);
        exp_q.delete();
        exp_q.push_back(32'hA0);
        exp_q.push_back(32'hB0);
        exp_q.push_back(32'hC0);
        exp_q.push_back(32'hD0);
        check_outs("t2_drain");

        // Flush of the two youngest stages.
        do_reset();
        dut_outs.delete();
        cycle(1'b1, 32'd4, 1'b0, '0);
        cycle(1'b1, 32'd3, 1'b0, '0);
        cycle(1'b1, 32'd2, 1'b0, '0);
        cycle(1'b1, 32'd1, 1'b0, '0);
        check("t3_full", 64'(stage_valid), 64'hF);
        cycle(1'b0, '0, 1'b0, 4'b0011);
        check("t3_after_flush", 64'(stage_valid), 64'hC);
        check("t3_stage0_zero", 64'(dut.g_stage[0].u_stage.data_q), 64'd0);
        check("t3_stage1_zero", 64'(dut.g_stage[1].u_stage.data_q), 64'd0);
        repeat (4) cycle(1'b0, '0, 1'b1, '0);
        exp_q.delete();
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd3);
        check_outs("t3_drain");

        // Flush at the output beats the output transfer.
        do_reset();
        dut_outs.delete();
        cycle(1'b1, 32'h5A, 1'b0, '0);
        repeat (3) cycle(1'b0, '0, 1'b0, '0);
        check("t4_out_valid", 64'(out_valid), 64'd1);
        check("t4_out_data", 64'(out_data), 64'h5A);
        cycle(1'b0, '0, 1'b1, 4'b1000);
        repeat (3) cycle(1'b0, '0, 1'b1, '0);
        check("t4_no_transfer", 64'(dut_outs.size()), 64'd0);

        // Reset while full.
        do_reset();
        repeat (4) cycle(1'b1, $urandom, 1'b0, '0);
        check("t5_occ_full", 64'(occupancy), 64'd4);
        do_reset();

`ifdef ELASTIC_PIPE_SKID_EN
        // Skid entry absorbs one word while the chain is stalled.
        do_reset();
        dut_outs.delete();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + i, 1'b0, '0);
        cycle(1'b1, 32'h77, 1'b0, '0);
        check("t6_occ_skid", 64'(occupancy), 64'd5);
        check("t6_in_ready", 64'(in_ready), 64'd0);
        repeat (8) cycle(1'b0, '0, 1'b1, '0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'h100 + i);
        exp_q.push_back(32'h77);
        check_outs("t6_drain");
`endif

        // Randomized traffic with sporadic flushes and resets.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [DEPTH-1:0] fl;
            for (int b = 0; b < DEPTH; b++) fl[b] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0), fl);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_chain.md
Name: elastic_pipe_chain

Overview:
- Parametrised successor to the single-stage pipeline register: a chain of DEPTH elastic stages, each WIDTH bits wide with its own valid bit.
- Uses valid/ready handshakes, bubble collapsing, per-stage flush and an occupancy count.
- Intended for CPU datapath segments, e.g. IF→ID→EX staging with branch-kill, and for decoupling queues between pipeline units.

Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 4, number of register stages; legal range 1..16.
- FLUSH_ZERO, 1, when 1 a flushed stage also clears its data to 0; when 0 only its valid bit is cleared.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  chain accepts in_data this cycle.
- in_data  in  WIDTH  payload in.
- out_valid  out  1  stage DEPTH-1 holds live data.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  payload out (data of stage DEPTH-1).
- flush  in  DEPTH  flush[i] kills the current content of stage i.
- stage_valid  out  DEPTH  raw valid bit of each stage.
- occupancy  out  $clog2(DEPTH+2)  number of live entries.

Behaviour:
- Reset:
  - Synchronous, active-high; clk and reset only.
  - All valid bits and data clear to 0; out_valid=0, stage_valid=0, occupancy=0.
  - in_ready is forced to 0 while reset is high.
- Stage indexing: stage 0 is nearest the input; stage DEPTH-1 drives the outputs.
- Effective valid: ev[i] = valid_q[i] & ~flush[i].
- Ready chain (combinational):
  - rdy[DEPTH-1] = ~ev[DEPTH-1] | out_ready.
  - rdy[i] = ~ev[i] | rdy[i+1].
  - in_ready = rdy[0].
  - Bubbles collapse: an empty stage accepts data even when downstream is stalled.
- Upstream valid: uv[0] = in_valid; uv[i] = ev[i-1].
- Stage update each clk:
  - If rdy[i]: valid_q[i] <= uv[i]. Data loads only when uv[i]=1; otherwise data holds, or clears to 0 when flush[i] is set and FLUSH_ZERO=1.
  - Else: valid_q[i] <= valid_q[i] (this cannot be a flushed stage, since flush forces rdy).
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_valid = ev[DEPTH-1]; out_valid does not depend on out_ready.
  - Once out_valid=1, out_data is stable until transfer or flush.
- Latency and throughput:
  - DEPTH cycles from input transfer to out_valid when the chain is empty.
  - Throughput is 1 transfer per cycle when out_ready is held at 1.
- Flush:
  - flush[i] kills stage i's content in the cycle it is asserted. That content never appears at the output and never advances.
  - Content moving from stage i-1 into stage i in the same cycle survives unless flush[i-1] is also set.
  - Younger/older kill policy is the caller's job: a branch kill drives flush[0..k].
- Simultaneous events:
  - flush[DEPTH-1] together with out_ready=1: no output transfer occurs.
  - An input transfer together with flush[0] is accepted, and the new word is live.
- occupancy: popcount of valid_q, registered, consistent with stage_valid.
- Reset mid-operation discards all content; in_ready returns to 1 the cycle after reset deasserts.
- The ready path is combinational across DEPTH stages. The optional skid buffer below breaks it.

Optional Feature:
- Macro: ELASTIC_PIPE_SKID_EN.
- Defined:
  - A 1-entry skid register is added before stage 0.
  - in_ready = ~skid_full, registered, with no combinational path from out_ready or flush.
  - A word accepted while rdy[0]=0 goes to the skid buffer. The skid buffer drains into stage 0 with priority over in_data.
  - Latency is unchanged when the skid buffer is empty. The skid buffer is never flushed.
  - occupancy counts the skid entry, up to DEPTH+1.
- Undefined: behaviour is exactly as above, and in_ready is combinational.

Decomposition:
- Shared package pipe_pkg:
  - Constant MAX_PIPE_DEPTH=16.
  - Function clog2_occ(depth) for the occupancy width.
  - Typedef pipe_stage_ctrl_t {valid, flush, ready} for benches.
- Sub-module elastic_pipe_stage:
  - One stage containing valid_q and data_q.
  - Inputs: uv, up_data, rdy, flush, FLUSH_ZERO.
  - Instantiated DEPTH times in a generate loop.
- The top level holds the ready chain, occupancy logic and the skid buffer.

Test Plan:
- Streaming: DEPTH=4, out_ready=1, send 0x11,0x22,0x33 back-to-back → out_data 0x11 at cycle 4 after first accept, then one word per cycle, occupancy peaks at 3.
- Backpressure with bubbles: send 0xA0 then idle 2 cycles then 0xB0, with out_ready=0 → both collapse to stages 3,2; in_ready stays 1 until 4 words are held; out_ready=1 → drains in order.
- Flush: stages 0..3 hold 1,2,3,4, stalled; assert flush=4'b0011 for one cycle → stage_valid=4'b1100; with out_ready=1, output is 4 then 3 only; data of stages 0 and 1 reads 0 (FLUSH_ZERO=1).
- Flush at output: out_valid=1 with 0x5A, pulse flush[3] with out_ready=1 → out_valid=0 that cycle, 0x5A is never transferred.
- Reset mid-stream: full chain, assert reset for 1 cycle → out_valid=0, occupancy=0, in_ready=0 during reset and 1 the next cycle.
- With ELASTIC_PIPE_SKID_EN: full chain stalled, in_valid=1 with 0x77 → accepted into skid, in_ready=0 the next cycle, occupancy=5; release out_ready → 0x77 emerges after the 4 older words.
